io_input_conditioner: RTL and testbench
=======================================

IO_INPUT_CONDITIONER -- requirements
Module: io_input_conditioner

Interface
REQ-001 Parameter DB_COUNT, default 50000, stable-sample count required to accept a new input value (minimum 2).
REQ-002 Parameter CNT_W, default 16, debounce counter width; DB_COUNT-1 SHALL fit in CNT_W bits.
REQ-003 clock  input  1  system clock, rising-edge active.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 sw0_raw  input  4  raw slide switches, asynchronous to clock.
REQ-006 sw1_raw  input  4  raw slide switches, asynchronous to clock.
REQ-007 key_raw  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clock.
REQ-008 event_clr  input  1  synchronous one-cycle request to clear key_event.
REQ-009 in_port0  output  4  debounced sw0 value, feeds data-memory IO read port 0.
REQ-010 in_port1  output  4  debounced sw1 value, feeds IO read port 1.
REQ-011 in_port2  output  1  debounced key level, 1 = pressed, feeds IO read port 2.
REQ-012 key_event  output  1  sticky flag, set on each debounced key press.
REQ-013 changed  output  1  one-cycle pulse when any debounced output updates.

Function
REQ-014 Three independent channels (sw0, sw1, key); each SHALL pass its raw input through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 Each channel SHALL hold registers: candidate, stable, counter[CNT_W-1:0].
REQ-016 At each edge, if s2 != candidate: candidate <= s2, counter <= 0.
REQ-017 Else if candidate == stable: counter <= 0.
REQ-018 Else if counter == DB_COUNT-1: stable <= candidate, counter <= 0.
REQ-019 Else: counter <= counter + 1; counter SHALL never wrap past DB_COUNT-1.
REQ-020 Latency: raw value first sampled into s1 at edge k and held SHALL appear on the output after edge k+DB_COUNT+2, not earlier.
REQ-021 Any raw change before acceptance SHALL restart the count from the new value (glitch shorter than DB_COUNT+1 cycles yields no output change).
REQ-022 A 4-bit channel SHALL debounce as a group: any bit change restarts that channel's counter.
REQ-023 in_port0/in_port1 SHALL equal stable of their channel; in_port2 SHALL equal the inverse of the key channel stable.
REQ-024 changed SHALL be registered, asserted the cycle after any channel's stable updates, for exactly one cycle per update edge (simultaneous updates give one pulse).
REQ-025 key_event SHALL set on the edge where in_port2 transitions 0->1 (registered, visible same cycle as changed).
REQ-026 key_event SHALL clear on an edge with event_clr = 1; if set and clear coincide, set SHALL win.
REQ-027 Key release (in_port2 1->0) SHALL NOT affect key_event.

Reset
REQ-028 On resetn = 0, immediately and independent of clock: sw0/sw1 s1, s2, candidate, stable = 0; counters = 0.
REQ-029 On reset key channel s1, s2, candidate, stable = 1 (released), so in_port2 = 0.
REQ-030 On reset in_port0 = 0, in_port1 = 0, in_port2 = 0, key_event = 0, changed = 0.
REQ-031 Reset asserted mid-count SHALL discard the pending candidate; after release a held raw value SHALL require full REQ-020 latency.
REQ-032 No changed or key_event pulse SHALL result from reset deassertion alone.

Verification (DB_COUNT = 4)
REQ-033 Reset release with sw0_raw = 4'hA held from edge 0 -> in_port0 = 0 through edge 5, 4'hA after edge 6, changed = 1 for one cycle after edge 7.
REQ-034 key_raw low for 3 cycles then high -> in_port2 stays 0, key_event stays 0, changed never asserts.
REQ-035 key_raw held low 10 cycles -> in_port2 = 1 after DB_COUNT+2 edges, key_event = 1 the following cycle; event_clr pulse -> key_event = 0; release -> key_event stays 0.
REQ-036 sw1_raw 0->3 then 3->7 two cycles later, held -> in_port1 goes directly 0->7, single changed pulse, never shows 3.
REQ-037 Debounced press coinciding with event_clr = 1 -> key_event = 1.
REQ-038 resetn pulsed low while sw0 count is at 2 -> in_port0 = 0 immediately; after release full 6-edge latency before update.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Debounced slide-switch and pushbutton inputs for the IO read ports.
// Each channel is synchronised, then must hold steady DB_COUNT cycles.

module io_debounce_chan #(
    parameter int W        = 4,
    parameter int DB_COUNT = 50000,
    parameter int CNT_W    = 16,
    parameter bit RST_ONE  = 1'b0
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [W-1:0] raw,
    output logic [W-1:0] stable,
    output logic [W-1:0] prev
);

    localparam logic [W-1:0]     RST  = {W{RST_ONE}};
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_COUNT - 1);

    logic [W-1:0]     s1;
    logic [W-1:0]     s2;
    logic [W-1:0]     cand;
    logic [W-1:0]     cand_d;
    logic [W-1:0]     stable_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;

    // A new candidate restarts the count; the counter saturates at LAST.
    always_comb begin
        cand_d   = cand;
        stable_d = stable;
        cnt_d    = '0;
        if (s2 != cand) begin
            cand_d = s2;
        end else if (cand == stable) begin
            cnt_d = '0;
        end else if (cnt == LAST) begin
            stable_d = cand;
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1     <= RST;
            s2     <= RST;
            cand   <= RST;
            stable <= RST;
            prev   <= RST;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            cand   <= cand_d;
            stable <= stable_d;
            prev   <= stable;
            cnt    <= cnt_d;
        end
    end

endmodule

module io_input_conditioner #(
    parameter int DB_COUNT = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [3:0] sw0_raw,
    input  logic [3:0] sw1_raw,
    input  logic       key_raw,
    input  logic       event_clr,
    output logic [3:0] in_port0,
    output logic [3:0] in_port1,
    output logic       in_port2,
    output logic       key_event,
    output logic       changed
);

    logic [3:0] sw0_stable;
    logic [3:0] sw0_prev;
    logic [3:0] sw1_stable;
    logic [3:0] sw1_prev;
    logic [0:0] key_stable;
    logic [0:0] key_prev;
    logic       upd;
    logic       press;

    io_debounce_chan #(
        .W(4), .DB_COUNT(DB_COUNT), .CNT_W(CNT_W), .RST_ONE(1'b0)
    ) u_sw0 (
        .clock  (clock),
        .resetn (resetn),
        .raw    (sw0_raw),
        .stable (sw0_stable),
        .prev   (sw0_prev)
    );

    io_debounce_chan #(
        .W(4), .DB_COUNT(DB_COUNT), .CNT_W(CNT_W), .RST_ONE(1'b0)
    ) u_sw1 (
        .clock  (clock),
        .resetn (resetn),
        .raw    (sw1_raw),
        .stable (sw1_stable),
        .prev   (sw1_prev)
    );

    // Key is active-low, so it resets to the released (1) level.
    io_debounce_chan #(
        .W(1), .DB_COUNT(DB_COUNT), .CNT_W(CNT_W), .RST_ONE(1'b1)
    ) u_key (
        .clock  (clock),
        .resetn (resetn),
        .raw    (key_raw),
        .stable (key_stable),
        .prev   (key_prev)
    );

    assign in_port0 = sw0_stable;
    assign in_port1 = sw1_stable;
    assign in_port2 = ~key_stable[0];

    assign upd   = (sw0_stable != sw0_prev) |
                   (sw1_stable != sw1_prev) |
                   (key_stable != key_prev);
    assign press = key_prev[0] & ~key_stable[0];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            changed   <= 1'b0;
            key_event <= 1'b0;
        end else begin
            changed <= upd;
            if (press) begin
                key_event <= 1'b1;
            end else if (event_clr) begin
                key_event <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DB_COUNT = 4.
// Expected output tuples are queued; a monitor checks each changed pulse.

module tb_io_input_conditioner;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] sw0_raw = 4'h0;
    logic [3:0] sw1_raw = 4'h0;
    logic       key_raw = 1'b1;
    logic       event_clr = 1'b0;
    logic [3:0] in_port0;
    logic [3:0] in_port1;
    logic       in_port2;
    logic       key_event;
    logic       changed;

    int n_vec = 0;
    int n_bad = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs;
    logic [9:0] exp_v;

    io_input_conditioner #(
        .DB_COUNT(4),
        .CNT_W(16)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .sw0_raw   (sw0_raw),
        .sw1_raw   (sw1_raw),
        .key_raw   (key_raw),
        .event_clr (event_clr),
        .in_port0  (in_port0),
        .in_port1  (in_port1),
        .in_port2  (in_port2),
        .key_event (key_event),
        .changed   (changed)
    );

    always #5 clock = ~clock;

    assign obs = {in_port0, in_port1, in_port2, key_event};

    always @(negedge clock) begin
        if (resetn && changed) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL changed_pulse: got pulse with outputs %h, expected no pulse", obs);
            end else begin
                exp_v = exp_q.pop_front();
                if (obs !== exp_v) begin
                    n_bad++;
                    $display("FAIL changed_pulse: got outputs %h, expected %h", obs, exp_v);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {22'd0, obs}, 32'd0);
        check("reset_changed", changed, 1'b0);

        // sw0 = A held from edge 0 after reset release
        @(negedge clock);
        resetn  = 1'b1;
        sw0_raw = 4'hA;
        exp_q.push_back({4'hA, 4'h0, 1'b0, 1'b0});
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            check($sformatf("sw0_lat_e%0d", i), in_port0,
                  (i >= 6) ? 4'hA : 4'h0);
        end
        wait_neg(4);

        // Key glitch of 3 cycles is rejected
        key_raw = 1'b0;
        wait_neg(3);
        key_raw = 1'b1;
        wait_neg(10);
        check("glitch_in_port2", in_port2, 1'b0);
        check("glitch_key_event", key_event, 1'b0);

        // Key held low 10 cycles, clear, then release
        key_raw = 1'b0;
        exp_q.push_back({4'hA, 4'h0, 1'b1, 1'b1});
        wait_neg(6);
        check("press_in_port2_e5", in_port2, 1'b0);
        @(negedge clock);
        check("press_in_port2_e6", in_port2, 1'b1);
        check("press_event_e6", key_event, 1'b0);
        @(negedge clock);
        check("press_event_e7", key_event, 1'b1);
        @(negedge clock);
        event_clr = 1'b1;
        @(negedge clock);
        event_clr = 1'b0;
        check("clr_event", key_event, 1'b0);
        key_raw = 1'b1;
        exp_q.push_back({4'hA, 4'h0, 1'b0, 1'b0});
        wait_neg(10);
        check("release_event", key_event, 1'b0);
        check("release_in_port2", in_port2, 1'b0);

        // sw1 0->3 then 3->7 two cycles later
        sw1_raw = 4'h3;
        wait_neg(2);
        sw1_raw = 4'h7;
        exp_q.push_back({4'hA, 4'h7, 1'b0, 1'b0});
        for (int j = 2; j <= 10; j++) begin
            @(negedge clock);
            check($sformatf("sw1_e%0d", j), in_port1,
                  (j >= 8) ? 4'h7 : 4'h0);
        end
        wait_neg(3);

        // Press coinciding with event_clr: set wins
        key_raw = 1'b0;
        exp_q.push_back({4'hA, 4'h7, 1'b1, 1'b1});
        wait_neg(6);
        event_clr = 1'b1;
        wait_neg(2);
        event_clr = 1'b0;
        check("set_wins_event", key_event, 1'b1);
        key_raw = 1'b1;
        exp_q.push_back({4'hA, 4'h7, 1'b0, 1'b1});
        wait_neg(10);
        check("release_keeps_event", key_event, 1'b1);
        check("release2_in_port2", in_port2, 1'b0);

        // Reset mid-count discards the pending sw0 candidate
        sw0_raw = 4'h5;
        wait_neg(5);
        resetn = 1'b0;
        #1;
        check("midreset_outputs", {22'd0, obs}, 32'd0);
        check("midreset_changed", changed, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        exp_q.push_back({4'h5, 4'h7, 1'b0, 1'b0});
        for (int i = 0; i <= 6; i++) begin
            @(negedge clock);
            check($sformatf("rel_sw0_e%0d", i), in_port0,
                  (i >= 6) ? 4'h5 : 4'h0);
            check($sformatf("rel_sw1_e%0d", i), in_port1,
                  (i >= 6) ? 4'h7 : 4'h0);
        end
        wait_neg(4);
        check("rel_key_event", key_event, 1'b0);

        check("pulses_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
